// File: rtl/jogo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : jogo_pkg
// Description : Shared definitions for the memory-game control unit: 4-bit
//               state codes (shown on the hex display) and the default
//               ESPERA timeout length.
// Revision    : 1.0 - initial release
// ============================================================================
package jogo_pkg;

  // State codes double as the db_estado display value
  typedef enum logic [3:0] {
    INICIAL     = 4'h0,
    PREPARACAO  = 4'h1,
    ESPERA      = 4'h2,
    REGISTRA    = 4'h3,
    COMPARACAO  = 4'h4,
    PROXIMO     = 4'h5,
    FIM_ACERTOU = 4'hA,
    FIM_TIMEOUT = 4'hC,
    FIM_ERROU   = 4'hE,
    ILLEGAL     = 4'hF
  } estado_t;

  // Cycles a player may spend in ESPERA before the round is lost
  localparam int unsigned c_timeout_cycles = 3000;

endpackage
`default_nettype wire

// File: rtl/contador_timeout.sv
`default_nettype none
// ============================================================================
// Module      : contador_timeout
// Description : Modulo-MODULO up counter with synchronous clear and enable.
//               fim is high while enabled on the last count, i.e. on the
//               MODULO-th consecutive enabled cycle after a clear.
// Revision    : 1.0 - initial release
// ============================================================================
module contador_timeout #(
  parameter int unsigned MODULO = 3000
) (
  input  logic clock,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic fim
);

  localparam int unsigned     c_w      = (MODULO > 2) ? $clog2(MODULO) : 1;
  localparam logic [c_w-1:0]  c_ultimo = c_w'(MODULO - 1);

  logic [c_w-1:0] r_conta;

  // Count enabled cycles; clear has priority over enable
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_conta <= '0;
    end else if (clr) begin
      r_conta <= '0;
    end else if (en) begin
      if (r_conta == c_ultimo) begin
        r_conta <= '0;
      end else begin
        r_conta <= r_conta + c_w'(1);
      end
    end
  end

  assign fim = en && (r_conta == c_ultimo);

endmodule
`default_nettype wire

// File: rtl/unidade_controle_jogada.sv
`default_nettype none
// ============================================================================
// Module      : unidade_controle_jogada
// Description : Moore control unit for the memory-game datapath. Clears the
//               datapath on iniciar, waits for each key press (edge of
//               jogada), registers and compares it, advances the address
//               counter on a hit and finishes in win, loss or timeout.
//               Build option TIMEOUT_EN: when defined, ESPERA is bounded by
//               TIMEOUT_CYCLES and FIM_TIMEOUT becomes reachable; otherwise
//               ESPERA waits forever and code 0xC is treated as illegal.
// Revision    : 1.0 - initial release
// ============================================================================
module unidade_controle_jogada
  import jogo_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = c_timeout_cycles
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iniciar,
  input  logic       jogada,
  input  logic       igual,
  input  logic       fimC,
  output logic       zeraC,
  output logic       contaC,
  output logic       zeraR,
  output logic       registraR,
  output logic       pronto,
  output logic       acertou,
  output logic       errou,
  output logic [3:0] db_estado
);

  estado_t r_estado;
  estado_t w_proximo;
  logic    r_jogada_q;
  logic    w_press;
  logic    w_timeout;
  logic    w_em_espera;

  // Only a rising edge of jogada counts, so a key already held when ESPERA
  // is entered must be released and pressed again.
  assign w_press     = jogada && !r_jogada_q;
  assign w_em_espera = (r_estado == ESPERA);

`ifdef TIMEOUT_EN
  logic w_fora_espera;
  assign w_fora_espera = !w_em_espera;

  contador_timeout #(
    .MODULO (TIMEOUT_CYCLES)
  ) u_contador_timeout (
    .clock (clock),
    .reset (reset),
    .clr   (w_fora_espera),
    .en    (w_em_espera),
    .fim   (w_timeout)
  );
`else
  assign w_timeout = 1'b0;
`endif

  // Codes that belong to this build; anything else shows as ILLEGAL
  function automatic logic estado_valido(input estado_t e);
    case (e)
      INICIAL, PREPARACAO, ESPERA, REGISTRA, COMPARACAO, PROXIMO,
      FIM_ACERTOU, FIM_ERROU: return 1'b1;
`ifdef TIMEOUT_EN
      FIM_TIMEOUT:            return 1'b1;
`endif
      default:                return 1'b0;
    endcase
  endfunction

  // Next-state selection; unknown codes recover to INICIAL
  always_comb begin
    w_proximo = INICIAL;
    case (r_estado)
      INICIAL: begin
        if (iniciar) w_proximo = PREPARACAO;
        else         w_proximo = INICIAL;
      end
      PREPARACAO: w_proximo = ESPERA;
      ESPERA: begin
        // A press on the same edge as the timeout still counts
        if (w_press)        w_proximo = REGISTRA;
        else if (w_timeout) w_proximo = FIM_TIMEOUT;
        else                w_proximo = ESPERA;
      end
      REGISTRA:   w_proximo = COMPARACAO;
      COMPARACAO: begin
        if (!igual)     w_proximo = FIM_ERROU;
        else if (fimC)  w_proximo = FIM_ACERTOU;
        else            w_proximo = PROXIMO;
      end
      PROXIMO:    w_proximo = ESPERA;
      FIM_ACERTOU: begin
        if (iniciar) w_proximo = PREPARACAO;
        else         w_proximo = FIM_ACERTOU;
      end
      FIM_ERROU: begin
        if (iniciar) w_proximo = PREPARACAO;
        else         w_proximo = FIM_ERROU;
      end
`ifdef TIMEOUT_EN
      FIM_TIMEOUT: begin
        if (iniciar) w_proximo = PREPARACAO;
        else         w_proximo = FIM_TIMEOUT;
      end
`endif
      default:    w_proximo = INICIAL;
    endcase
  end

  // State register with outputs registered as a decode of the next state,
  // so every output is a pure function of the state held this cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_estado   <= INICIAL;
      r_jogada_q <= 1'b0;
      zeraC      <= 1'b0;
      contaC     <= 1'b0;
      zeraR      <= 1'b0;
      registraR  <= 1'b0;
      pronto     <= 1'b0;
      acertou    <= 1'b0;
      errou      <= 1'b0;
    end else begin
      r_estado   <= w_proximo;
      r_jogada_q <= jogada;
      zeraC      <= (w_proximo == PREPARACAO);
      zeraR      <= (w_proximo == PREPARACAO);
      contaC     <= (w_proximo == PROXIMO);
      registraR  <= (w_proximo == REGISTRA);
      pronto     <= (w_proximo == FIM_ACERTOU) || (w_proximo == FIM_ERROU) ||
                    (w_proximo == FIM_TIMEOUT);
      acertou    <= (w_proximo == FIM_ACERTOU);
      errou      <= (w_proximo == FIM_ERROU) || (w_proximo == FIM_TIMEOUT);
    end
  end

  assign db_estado = estado_valido(r_estado) ? r_estado : ILLEGAL;

endmodule
`default_nettype wire

// File: tb/tb_unidade_controle_jogada.sv
`default_nettype none
// ============================================================================
// Module      : tb_unidade_controle_jogada
// Description : Self-checking bench for unidade_controle_jogada. Rounds are
//               described at game level (round length, index of the first
//               wrong key) and the expected display codes, pulse counts and
//               final outcome follow from the game rules.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_unidade_controle_jogada;

  localparam int unsigned TO = 10;

  logic       clock = 1'b0;
  logic       reset;
  logic       iniciar, jogada, igual, fimC;
  logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int n_zc = 0, n_cc = 0, n_zr = 0, n_rr = 0;

  unidade_controle_jogada #(.TIMEOUT_CYCLES(TO)) dut (
    .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
    .igual(igual), .fimC(fimC), .zeraC(zeraC), .contaC(contaC),
    .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
    .acertou(acertou), .errou(errou), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  // Pulse counters sampled mid-cycle
  always @(negedge clock) begin
    if (zeraC)     n_zc <= n_zc + 1;
    if (contaC)    n_cc <= n_cc + 1;
    if (zeraR)     n_zr <= n_zr + 1;
    if (registraR) n_rr <= n_rr + 1;
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimC = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
  endtask

  // One key press: jogada high for 'hold' cycles, codes of the 3 following cycles
  task automatic press(input logic ig, input logic fc, input int hold,
                       output logic [3:0] c1, output logic r1,
                       output logic [3:0] c2, output logic [3:0] c3);
    igual = ig; fimC = fc; jogada = 1'b1;
    tick(); c1 = db_estado; r1 = registraR;
    if (hold < 2) jogada = 1'b0;
    tick(); c2 = db_estado;
    jogada = 1'b0;
    tick(); c3 = db_estado;
  endtask

  task automatic test_reset();
    logic [6:0] outs;
    reset = 1'b0; iniciar = 1'b0; jogada = 1'b0; igual = 1'b0; fimC = 1'b0;
    tick(); tick();
    outs = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou};
    checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL reset_state got %h exp 0", db_estado); end
    checks++; if (outs !== 7'b0) begin errors++; $display("FAIL reset_outputs got %b exp 0000000", outs); end
    reset = 1'b1;
    tick(); tick(); tick();
    checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL idle_no_iniciar got %h exp 0", db_estado); end
    // Drive into COMPARACAO, then reset asynchronously mid-cycle
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    igual = 1'b1; fimC = 1'b0; jogada = 1'b1;
    tick(); jogada = 1'b0; tick();
    checks++; if (db_estado !== 4'h4) begin errors++; $display("FAIL reach_comparacao got %h exp 4", db_estado); end
    #2 reset = 1'b0;
    #1;
    outs = {zeraC, contaC, zeraR, registraR, pronto, acertou, errou};
    checks++; if (db_estado !== 4'h0) begin errors++; $display("FAIL async_reset_state got %h exp 0", db_estado); end
    checks++; if (outs !== 7'b0) begin errors++; $display("FAIL async_reset_outputs got %b exp 0000000", outs); end
    tick(); reset = 1'b1;
    tick(); tick();
    checks++; if (db_estado !== 4'h0 || contaC !== 1'b0) begin errors++; $display("FAIL after_reset_idle got %h/%b exp 0/0", db_estado, contaC); end
  endtask

  task automatic test_win();
    int n, zc0, cc0, zr0, rr0, bad;
    logic [3:0] c1, c2, c3; logic r1;
    do_reset();
    n = 4; bad = 0;
    zc0 = n_zc; cc0 = n_cc; zr0 = n_zr; rr0 = n_rr;
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    checks++; if (db_estado !== 4'h1 || zeraC !== 1'b1 || zeraR !== 1'b1) begin errors++; $display("FAIL win_prep got %h zc=%b zr=%b exp 1 1 1", db_estado, zeraC, zeraR); end
    tick();
    checks++; if (db_estado !== 4'h2) begin errors++; $display("FAIL win_espera got %h exp 2", db_estado); end
    for (int p = 0; p < n; p++) begin
      repeat ($urandom_range(0, 3)) begin tick(); if (db_estado !== 4'h2) bad++; end
      press(1'b1, (p == n - 1), 1, c1, r1, c2, c3);
      if (c1 !== 4'h3 || r1 !== 1'b1 || c2 !== 4'h4) bad++;
      if (c3 !== ((p == n - 1) ? 4'hA : 4'h5)) bad++;
      if (p != n - 1) begin tick(); if (db_estado !== 4'h2) bad++; end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL win_sequence got %0d bad cycles exp 0", bad); end
    checks++; if ({pronto, acertou, errou} !== 3'b110) begin errors++; $display("FAIL win_flags got %b exp 110", {pronto, acertou, errou}); end
    tick(); tick();
    checks++; if (db_estado !== 4'hA) begin errors++; $display("FAIL win_hold got %h exp A", db_estado); end
    checks++; if (n_rr - rr0 != n || n_cc - cc0 != n - 1 || n_zc - zc0 != 1 || n_zr - zr0 != 1)
      begin errors++; $display("FAIL win_counts got rr=%0d cc=%0d zc=%0d zr=%0d exp %0d %0d 1 1", n_rr - rr0, n_cc - cc0, n_zc - zc0, n_zr - zr0, n, n - 1); end
  endtask

  task automatic test_mismatch();
    int n, m;
    logic [3:0] c1, c2, c3; logic r1;
    do_reset();
    n = $urandom_range(3, 6); m = 1;
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    c3 = 4'h0;
    for (int p = 0; p <= m; p++) begin
      press((p != m), (p == n - 1), 1, c1, r1, c2, c3);
      if (p != m) tick();
    end
    checks++; if (c3 !== 4'hE) begin errors++; $display("FAIL mismatch_state got %h exp E", c3); end
    checks++; if ({pronto, acertou, errou} !== 3'b101) begin errors++; $display("FAIL mismatch_flags got %b exp 101", {pronto, acertou, errou}); end
    iniciar = 1'b1; tick(); iniciar = 1'b0;
    checks++; if (db_estado !== 4'h1 || zeraC !== 1'b1 || zeraR !== 1'b1) begin errors++; $display("FAIL restart_prep got %h zc=%b zr=%b exp 1 1 1", db_estado, zeraC, zeraR); end
    tick();
    checks++; if (db_estado !== 4'h2 || pronto !== 1'b0) begin errors++; $display("FAIL restart_espera got %h/%b exp 2/0", db_estado, pronto); end
  endtask

  task automatic test_held();
    int bad;
    do_reset();
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    igual = 1'b1; fimC = 1'b0; jogada = 1'b1;
    tick(); tick(); tick(); tick();
    checks++; if (db_estado !== 4'h2) begin errors++; $display("FAIL held_back_espera got %h exp 2", db_estado); end
    bad = 0;
    repeat (4) begin tick(); if (db_estado !== 4'h2 || registraR !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL held_no_register got %0d bad cycles exp 0", bad); end
    jogada = 1'b0; tick();
    jogada = 1'b1; tick();
    checks++; if (db_estado !== 4'h3 || registraR !== 1'b1) begin errors++; $display("FAIL held_repress got %h/%b exp 3/1", db_estado, registraR); end
    jogada = 1'b0;
  endtask

  task automatic test_iniciar_ignored();
    do_reset();
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    iniciar = 1'b1; tick();
    checks++; if (db_estado !== 4'h2 || zeraC !== 1'b0) begin errors++; $display("FAIL ignore_espera got %h/%b exp 2/0", db_estado, zeraC); end
    igual = 1'b1; fimC = 1'b0; jogada = 1'b1; tick(); jogada = 1'b0;
    checks++; if (db_estado !== 4'h3) begin errors++; $display("FAIL ignore_press got %h exp 3", db_estado); end
    tick();
    checks++; if (db_estado !== 4'h4) begin errors++; $display("FAIL ignore_registra got %h exp 4", db_estado); end
    iniciar = 1'b0; tick();
    checks++; if (db_estado !== 4'h5 || contaC !== 1'b1) begin errors++; $display("FAIL ignore_proximo got %h/%b exp 5/1", db_estado, contaC); end
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
`ifdef TIMEOUT_EN
    cnt = 1;
    while (db_estado == 4'h2 && cnt < 50) begin tick(); if (db_estado == 4'h2) cnt++; end
    checks++; if (cnt != TO || db_estado !== 4'hC) begin errors++; $display("FAIL timeout_length got %0d cycles state %h exp %0d C", cnt, db_estado, TO); end
    checks++; if ({pronto, acertou, errou} !== 3'b101) begin errors++; $display("FAIL timeout_flags got %b exp 101", {pronto, acertou, errou}); end
    iniciar = 1'b1; tick(); iniciar = 1'b0; tick();
    repeat (TO - 1) tick();
    checks++; if (db_estado !== 4'h2) begin errors++; $display("FAIL timeout_last_cycle got %h exp 2", db_estado); end
    igual = 1'b1; fimC = 1'b0; jogada = 1'b1; tick(); jogada = 1'b0;
    checks++; if (db_estado !== 4'h3) begin errors++; $display("FAIL timeout_press_wins got %h exp 3", db_estado); end
`else
    cnt = 0;
    repeat (3 * TO) begin tick(); if (db_estado !== 4'h2) cnt++; end
    checks++; if (cnt != 0) begin errors++; $display("FAIL no_timeout got %0d non-ESPERA cycles exp 0", cnt); end
    igual = 1'b1; fimC = 1'b1; jogada = 1'b1; tick(); jogada = 1'b0;
    checks++; if (db_estado !== 4'h3) begin errors++; $display("FAIL late_press got %h exp 3", db_estado); end
`endif
  endtask

  task automatic test_random_rounds();
    int n, m, rr0, cc0, bad, last;
    logic [3:0] c1, c2, c3, exp_fim; logic r1;
    do_reset();
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 5);
      m = $urandom_range(0, n);          // m == n means every key matches
      rr0 = n_rr; cc0 = n_cc; bad = 0;
      last = (m < n) ? m : n - 1;
      exp_fim = (m < n) ? 4'hE : 4'hA;
      iniciar = 1'b1; tick(); iniciar = 1'b0;
      if (db_estado !== 4'h1) bad++;
      tick();
      c3 = 4'h0;
      for (int p = 0; p <= last; p++) begin
        repeat ($urandom_range(0, 2)) begin tick(); if (db_estado !== 4'h2) bad++; end
        press((p != m), (p == n - 1), $urandom_range(1, 2), c1, r1, c2, c3);
        if (c1 !== 4'h3 || r1 !== 1'b1 || c2 !== 4'h4) bad++;
        if (p != last) begin
          if (c3 !== 4'h5) bad++;
          tick();
        end
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL rnd%0d_sequence got %0d bad cycles exp 0", r, bad); end
      checks++; if (c3 !== exp_fim || acertou !== (m >= n) || errou !== (m < n) || pronto !== 1'b1)
        begin errors++; $display("FAIL rnd%0d_outcome got %h a=%b e=%b p=%b exp %h", r, c3, acertou, errou, pronto, exp_fim); end
      checks++; if (n_rr - rr0 != last + 1 || n_cc - cc0 != last)
        begin errors++; $display("FAIL rnd%0d_counts got rr=%0d cc=%0d exp %0d %0d", r, n_rr - rr0, n_cc - cc0, last + 1, last); end
    end
  endtask

  initial begin
    test_reset();
    test_win();
    test_mismatch();
    test_held();
    test_iniciar_ignored();
    test_timeout();
    test_random_rounds();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
